// File: rtl/updown_terminal_counter.sv
// Up/down counter with programmable limit, wrap/saturate modes, synchronous load
// and a registered terminal-count pulse with a sticky saturate-done flag.
module updown_terminal_counter #(
    parameter int               WIDTH   = 25,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_done,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             done_nxt;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    // Counting up from above a freshly lowered limit is treated as terminal.
    assign at_term      = dir ? (count >= limit) : (count == '0);
    assign load_clamped = (load_val > limit) ? limit : load_val;

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        done_nxt  = done;
        if (load) begin
            count_nxt = load_clamped;
            done_nxt  = 1'b0;
        end else begin
            if (clr_done)
                done_nxt = 1'b0;
            if (en) begin
                if (!at_term) begin
                    count_nxt = dir ? count + WIDTH'(1) : count - WIDTH'(1);
                end else if (wrap) begin
                    count_nxt = dir ? '0 : limit;
                    tc_nxt    = 1'b1;
                end else if (!done && !clr_done) begin
                    // Saturate: flag once, a pending clear blocks re-arming this edge.
                    done_nxt = 1'b1;
                    tc_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            done  <= done_nxt;
        end
    end

endmodule
